// File: rtl/clk_sw_pkg.sv
// Shared types and constants for the clock-switch sequencer and its activity monitor.
package clk_sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DEAD     = 2'd1;
    localparam logic [1:0] ERR_FAILOVER = 2'd2;

    function automatic int cnt_width(input int settle_cyc, input int alive_win);
        int max_cyc;
        max_cyc = (settle_cyc > alive_win) ? settle_cyc : alive_win;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// clkb liveness monitor: a clkb-domain toggle counter whose MSB is synchronised into clka
// and counted over fixed windows of clka cycles.
module clk_activity_mon
    import clk_sw_pkg::*;
#(
    parameter int ALIVE_WIN = 32,
    parameter int ALIVE_MIN = 2,
    parameter int CW        = cnt_width(8, ALIVE_WIN)
) (
    input  logic rst_n,
    input  logic clka,
    input  logic clkb,
    input  logic mon_restart,
    output logic clkb_alive,
    output logic win_end
);

    localparam int EW = $clog2(ALIVE_MIN + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(ALIVE_WIN - 1);
    localparam logic [EW-1:0] EVT_MIN  = EW'(ALIVE_MIN);

    logic [1:0]    cnt_b_q, cnt_b_d;
    logic          sync1_q, sync2_q, msb_prev_q;
    logic [CW-1:0] win_q, win_d;
    logic [EW-1:0] evt_q, evt_d, evt_sat;
    logic          alive_q, alive_d;
    logic          win_end_q, win_end_d;
    logic          evt_seen, win_last;

    always_comb cnt_b_d = cnt_b_q + 2'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) cnt_b_q <= '0;
        else        cnt_b_q <= cnt_b_d;
    end

    // Two-flop synchroniser on the slow-toggling MSB; only its edges cross domains.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            msb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= cnt_b_q[1];
            sync2_q    <= sync1_q;
            msb_prev_q <= sync2_q;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        evt_seen  = sync2_q ^ msb_prev_q;
        win_last  = (win_q == WIN_LAST);
        evt_sat   = (evt_q >= EVT_MIN) ? evt_q : evt_q + EW'(evt_seen);
        win_d     = win_q + CW'(1);
        evt_d     = evt_sat;
        alive_d   = alive_q;
        win_end_d = 1'b0;
        if (mon_restart) begin
            win_d = '0;
            evt_d = '0;
        end else if (win_last) begin
            win_d     = '0;
            evt_d     = '0;
            alive_d   = (evt_sat >= EVT_MIN);
            win_end_d = 1'b1;
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            evt_q     <= '0;
            alive_q   <= 1'b0;
            win_end_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            evt_q     <= evt_d;
            alive_q   <= alive_d;
            win_end_q <= win_end_d;
        end
    end

    assign clkb_alive = alive_q;
    assign win_end    = win_end_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock switch sequencer on clka. Define CLK_SW_FAILOVER_EN to fall back to
// clka automatically when clkb stops while it is the selected source.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int ALIVE_WIN  = 32,
    parameter int ALIVE_MIN  = 2
) (
    input  logic       rst_n,
    input  logic       clka,
    input  logic       clkb,
    input  logic       req_valid,
    input  logic       req_src,
    output logic       req_ready,
    output logic       sel,
    output logic       cur_src,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       clkb_alive
);

    localparam int CW = cnt_width(SETTLE_CYC, ALIVE_WIN);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] settle_q, settle_d;
    logic          sel_q, sel_d;
    logic          cur_src_q, cur_src_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          fo_q, fo_d;
    logic          mon_restart, win_end, accept, fo_trig;

    clk_activity_mon #(
        .ALIVE_WIN (ALIVE_WIN),
        .ALIVE_MIN (ALIVE_MIN),
        .CW        (CW)
    ) u_mon (
        .rst_n       (rst_n),
        .clka        (clka),
        .clkb        (clkb),
        .mon_restart (mon_restart),
        .clkb_alive  (clkb_alive),
        .win_end     (win_end)
    );

`ifdef CLK_SW_FAILOVER_EN
    logic alive_prev_q;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) alive_prev_q <= 1'b0;
        else        alive_prev_q <= clkb_alive;
    end

    assign fo_trig = (state_q == ST_IDLE) && cur_src_q && alive_prev_q && !clkb_alive;
`else
    assign fo_trig = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE) && !fo_trig;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        sel_d       = sel_q;
        cur_src_d   = cur_src_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        fo_d        = fo_q;
        mon_restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fo_trig) begin
                    state_d  = ST_SWITCH;
                    sel_d    = 1'b0;
                    settle_d = SETTLE_LOAD;
                    fo_d     = 1'b1;
                end else if (accept) begin
                    err_code_d = ERR_NONE;
                    fo_d       = 1'b0;
                    if (req_src == cur_src_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else if (!req_src) begin
                        state_d  = ST_SWITCH;
                        sel_d    = 1'b0;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d     = ST_CHECK;
                        mon_restart = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (win_end) begin
                    if (clkb_alive) begin
                        state_d  = ST_SWITCH;
                        sel_d    = 1'b1;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d    = ST_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_DEAD;
                    end
                end
            end
            ST_SWITCH: begin
                if (settle_q == '0) begin
                    state_d   = ST_FINISH;
                    cur_src_d = sel_q;
                    if (fo_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FAILOVER;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            sel_q      <= 1'b0;
            cur_src_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            fo_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            sel_q      <= sel_d;
            cur_src_q  <= cur_src_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            fo_q       <= fo_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign sel      = sel_q;
    assign cur_src  = cur_src_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl: switching, dead clkb, busy handling, mid-sequence reset
// and (with CLK_SW_FAILOVER_EN) automatic failover.
module tb_clk_switch_ctrl;

    localparam int SETTLE = 8;
    localparam int WIN    = 32;

    logic       rst_n = 1'b1;
    logic       clka = 1'b0;
    logic       clkb = 1'b0;
    logic       clkb_en = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_src = 1'b0;
    logic       req_ready, sel, cur_src, busy, done, err, clkb_alive;
    logic [1:0] err_code;
    int         checks = 0;
    int         errors = 0;

    clk_switch_ctrl #(
        .SETTLE_CYC (SETTLE),
        .ALIVE_WIN  (WIN),
        .ALIVE_MIN  (2)
    ) dut (
        .rst_n      (rst_n),
        .clka       (clka),
        .clkb       (clkb),
        .req_valid  (req_valid),
        .req_src    (req_src),
        .req_ready  (req_ready),
        .sel        (sel),
        .cur_src    (cur_src),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .clkb_alive (clkb_alive)
    );

    always #5 clka = ~clka;

    always begin
        #15;
        if (clkb_en) clkb = ~clkb;
        else         clkb = 1'b0;
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic issue(input logic src);
        int k = 0;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        req_valid = 1'b1;
        req_src   = src;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        clkb_en = 1'b1;
        #2 rst_n = 1'b0;
        #15;
        checks++;
        if ({sel, cur_src, busy, req_ready, done, err, err_code, clkb_alive} !== 9'b000100000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b",
                     {sel, cur_src, busy, req_ready, done, err, err_code, clkb_alive}, 9'b000100000);
        end
        @(negedge clka);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({sel, cur_src, busy, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", {sel, cur_src, busy, req_ready}, 4'b0001);
        end
    endtask

    task automatic test_switch_to_clkb();
        int   n;
        int   sel_changes;
        logic prev;
        issue(1'b1);
        checks++;
        if ({busy, req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL clkb_busy_c1: got %b expected %b", {busy, req_ready}, 2'b10);
        end
        n = 1;
        sel_changes = 0;
        prev = sel;
        while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (sel !== prev) begin
                sel_changes++;
                prev = sel;
            end
        end
        checks++;
        if (n !== WIN + SETTLE + 2) begin
            errors++;
            $display("FAIL clkb_latency: got %0d expected %0d", n, WIN + SETTLE + 2);
        end
        checks++;
        if ({done, err, sel, cur_src, clkb_alive, err_code} !== 7'b1011100) begin
            errors++;
            $display("FAIL clkb_result: got %b expected %b",
                     {done, err, sel, cur_src, clkb_alive, err_code}, 7'b1011100);
        end
        checks++;
        if (sel_changes !== 1) begin
            errors++;
            $display("FAIL clkb_sel_stable: got %0d expected %0d", sel_changes, 1);
        end
        tick();
    endtask

    task automatic test_switch_to_clka();
        int n;
        issue(1'b0);
        checks++;
        if (sel !== 1'b0) begin
            errors++;
            $display("FAIL clka_sel_c1: got %b expected %b", sel, 1'b0);
        end
        wait_resp(n);
        checks++;
        if (n !== SETTLE + 1) begin
            errors++;
            $display("FAIL clka_latency: got %0d expected %0d", n, SETTLE + 1);
        end
        checks++;
        if ({done, err, cur_src} !== 3'b100) begin
            errors++;
            $display("FAIL clka_result: got %b expected %b", {done, err, cur_src}, 3'b100);
        end
        tick();
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clka_done_pulse: got %b expected %b", {done, req_ready}, 2'b01);
        end
    endtask

    task automatic test_dead_clkb();
        int n;
        clkb_en = 1'b0;
        repeat (10) tick();
        issue(1'b1);
        wait_resp(n);
        checks++;
        if (n < WIN + 1 || n > WIN + 2) begin
            errors++;
            $display("FAIL dead_latency: got %0d expected %0d..%0d", n, WIN + 1, WIN + 2);
        end
        checks++;
        if ({err, done, err_code, sel, cur_src} !== 6'b100100) begin
            errors++;
            $display("FAIL dead_result: got %b expected %b", {err, done, err_code, sel, cur_src}, 6'b100100);
        end
        tick();
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL dead_err_pulse: got %b expected %b", {err, busy}, 2'b00);
        end
        repeat (3) tick();
        checks++;
        if (err_code !== 2'd1) begin
            errors++;
            $display("FAIL dead_code_held: got %0d expected %0d", err_code, 1);
        end
    endtask

    task automatic test_same_src_and_busy();
        int n;
        clkb_en = 1'b1;
        repeat (4) tick();
        issue(1'b0);
        checks++;
        if ({done, busy, sel, err_code} !== 5'b11000) begin
            errors++;
            $display("FAIL same0_result: got %b expected %b", {done, busy, sel, err_code}, 5'b11000);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL same0_idle: got %b expected %b", {done, busy}, 2'b00);
        end
        req_valid = 1'b1;
        req_src   = 1'b1;
        tick();
        req_src = 1'b0;
        n = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({req_ready, busy} !== 2'b01) begin
                errors++;
                $display("FAIL busy_ignore_%0d: got %b expected %b", i, {req_ready, busy}, 2'b01);
            end
            tick();
            n++;
        end
        req_valid = 1'b0;
        while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== WIN + SETTLE + 2 || {done, sel, cur_src} !== 3'b111) begin
            errors++;
            $display("FAIL busy_switch: got n=%0d %b expected n=%0d %b",
                     n, {done, sel, cur_src}, WIN + SETTLE + 2, 3'b111);
        end
        tick();
        issue(1'b1);
        checks++;
        if ({done, sel, cur_src} !== 3'b111) begin
            errors++;
            $display("FAIL same1_result: got %b expected %b", {done, sel, cur_src}, 3'b111);
        end
        tick();
    endtask

    task automatic test_reset_mid_switch();
        int n;
        int k;
        int seen;
        issue(1'b0);
        wait_resp(n);
        checks++;
        if ({done, cur_src} !== 2'b10 || n !== SETTLE + 1) begin
            errors++;
            $display("FAIL prep_clka: got n=%0d %b expected n=%0d %b", n, {done, cur_src}, SETTLE + 1, 2'b10);
        end
        tick();
        issue(1'b1);
        k = 0;
        while (sel !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        repeat (3) tick();
        checks++;
        if ({sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre: got %b expected %b", {sel, busy}, 2'b11);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, busy, cur_src, done, err} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", {sel, busy, cur_src, done, err}, 5'b00000);
        end
        @(negedge clka);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || err === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got pulses=%0d ready=%b expected pulses=0 ready=1", seen, req_ready);
        end
    endtask

    task automatic test_failover();
        int   n;
        int   sel_fall;
        int   err_at;
        int   done_seen;
        logic [1:0] code;
        issue(1'b1);
        wait_resp(n);
        checks++;
        if ({done, cur_src} !== 2'b11) begin
            errors++;
            $display("FAIL fo_prep: got %b expected %b", {done, cur_src}, 2'b11);
        end
        tick();
        clkb_en   = 1'b0;
        sel_fall  = -1;
        err_at    = -1;
        done_seen = 0;
        code      = 2'd0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (sel === 1'b0 && sel_fall < 0) sel_fall = i;
            if (err === 1'b1 && err_at < 0) begin
                err_at = i;
                code   = err_code;
            end
            if (done === 1'b1) done_seen++;
        end
`ifdef CLK_SW_FAILOVER_EN
        checks++;
        if (sel_fall < 1 || sel_fall > 2 * WIN + 4) begin
            errors++;
            $display("FAIL fo_sel_fall: got %0d expected 1..%0d", sel_fall, 2 * WIN + 4);
        end
        checks++;
        if (err_at !== sel_fall + SETTLE || code !== 2'd2) begin
            errors++;
            $display("FAIL fo_err: got at=%0d code=%0d expected at=%0d code=2", err_at, code, sel_fall + SETTLE);
        end
        checks++;
        if (done_seen !== 0 || {sel, cur_src} !== 2'b00) begin
            errors++;
            $display("FAIL fo_final: got done=%0d %b expected done=0 %b", done_seen, {sel, cur_src}, 2'b00);
        end
`else
        checks++;
        if (sel_fall !== -1 || err_at !== -1 || done_seen !== 0) begin
            errors++;
            $display("FAIL nofo_quiet: got fall=%0d err=%0d done=%0d expected -1 -1 0", sel_fall, err_at, done_seen);
        end
        checks++;
        if ({sel, cur_src, clkb_alive} !== 3'b110) begin
            errors++;
            $display("FAIL nofo_final: got %b expected %b", {sel, cur_src, clkb_alive}, 3'b110);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_switch_to_clkb();
        test_switch_to_clka();
        test_dead_clkb();
        test_same_src_and_busy();
        test_reset_mid_switch();
        test_failover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
